memtrace_replay_sequencer: RTL and testbench
============================================

# memtrace_replay_sequencer

Controller that drives the simulated memory-trace source through replay and serializes its per-lane requests onto a single memory request port. It sits between the trace source (per-lane `trace_read_*` bundle, advanced with `trace_read_ready` and `trace_read_cycle`) and the downstream memory request channel. It steps the trace cycle counter, snapshots each cycle's lanes, arbitrates the valid lanes one per handshake, and reports completion.

## Interface
- `NUM_LANES`, 4, lane count; legal range 1..32
- `ADDR_W`, 64, width of address and data per lane
- `SIZE_W`, 8, width of the log2-size field per lane
- `LANE_W`, derived as max(1, $clog2(NUM_LANES)), width of the lane index
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `trace_read_ready`  out  1  asks the trace source to load the lanes for `trace_read_cycle` on this edge
- `trace_read_cycle`  out  64  trace cycle to fetch
- `trace_read_valid`  in  NUM_LANES  per-lane valid from the source
- `trace_read_address`  in  ADDR_W*NUM_LANES  lane g occupies bits [ADDR_W*(g+1)-1 : ADDR_W*g]
- `trace_read_is_store`  in  NUM_LANES  per-lane store flag
- `trace_read_size`  in  SIZE_W*NUM_LANES  per-lane log2 size, packed the same way as the address
- `trace_read_data`  in  ADDR_W*NUM_LANES  per-lane store data, packed the same way as the address
- `trace_read_finished`  in  1  trace exhausted
- `req_valid`  out  1  request available
- `req_ready`  in  1  downstream accepts
- `req_address`  out  ADDR_W  address of the granted lane
- `req_is_store`  out  1  store flag of the granted lane
- `req_size`  out  SIZE_W  log2 size of the granted lane
- `req_data`  out  ADDR_W  data of the granted lane
- `req_lane`  out  LANE_W  index of the granted lane
- `done`  out  1  replay complete; sticky until reset

## Operation
- **States:** START, FETCH, LATCH, ISSUE, DONE. Reset enters START.
- **START → FETCH:** unconditional.
- **FETCH:**
  - `trace_read_ready`=1; `trace_read_cycle` = counter.
  - On leaving, counter increments by 1, wrapping modulo 2^64.
  - Next state is LATCH.
- **LATCH:**
  - The source outputs are now valid for the fetched cycle.
  - Capture every lane's address, is_store, size and data into snapshot registers.
  - `pending` ← `trace_read_valid`; `fin` ← `trace_read_finished`.
  - If `trace_read_valid`==0: go to DONE when `trace_read_finished`=1, otherwise go to FETCH.
  - If any lane is valid: go to ISSUE.
- **ISSUE:**
  - `req_valid` = |pending.
  - The `req_*` payload comes from the snapshot of the granted lane.
  - On `req_valid && req_ready`, clear the granted bit in `pending`.
  - When the last bit clears, go to DONE if `fin`=1, otherwise go to FETCH.
- **DONE:** `done`=1, `trace_read_ready`=0, `req_valid`=0. Leave only on reset.
- **Grant:** a pure function of the registered `pending` (and the pointer, when the round-robin feature is compiled in). It therefore cannot change while `req_valid && !req_ready`; payload and `req_lane` stay stable until accepted.
- **Invalid lanes:** lanes with valid=0 are never issued, and their snapshot contents are don't-care.

## Timing
- **Reset values:** `trace_read_ready`=0, `trace_read_cycle`=0, `req_valid`=0, `req_lane`=0, `done`=0; `pending`=0; counter=0; RR pointer=0.
- **Reset mid-operation:** discards the snapshot and all pending lanes; replay restarts at cycle 0.
- **First fetch:** one cycle of START after reset deasserts, then FETCH of cycle 0.
- **`trace_read_ready` pulse:** exactly 1 cycle wide per trace cycle.
- **Trace cycle with k valid lanes, `req_ready` held high:** k+2 clocks (FETCH, LATCH, k ISSUE).
- **Empty trace cycle:** 2 clocks.
- **Backpressure:** `req_ready`=0 stalls in ISSUE indefinitely, with no fetch.
- **Last acceptance:** acceptance of the final pending lane is followed by FETCH (or DONE) on the very next cycle; there are no idle bubbles.
- **Ports:** `req_*` outputs are combinational from registers only; there is no input-to-output path.

## Configuration
- **`MEMTRACE_SEQ_RR_EN` defined:**
  - Round-robin grant: the first pending lane at or above `rr_ptr`, wrapping to lane 0.
  - On acceptance of lane g, `rr_ptr` ← (g+1) mod NUM_LANES.
  - `rr_ptr` persists across trace cycles.
- **Undefined:** fixed priority, lowest pending index first; no pointer register exists.

## Structure
- **Package `memtrace_seq_pkg`:**
  - State enum `seq_state_e`.
  - `MEMTRACE_DATA_WIDTH`=64, `MEMTRACE_LOGSIZE_WIDTH`=8, `MAX_NUM_LANES`=32.
- **Sub-module `memtrace_lane_picker`:**
  - Parameterized by NUM_LANES.
  - Inputs: pending mask and pointer.
  - Outputs: one-hot grant, its encoded index, and any-valid.
  - Contains the compile-time choice between round-robin and fixed priority.

## Test plan
- **Single full cycle:** NUM_LANES=4; cycle 0 has lanes 0–3 valid with addresses 0x1000/0x1008/0x1010/0x1018, `req_ready`=1 → four requests on consecutive clocks (order 0,1,2,3); the next `trace_read_ready` pulse carries `trace_read_cycle`=1, 6 clocks after the first FETCH.
- **Sparse lanes:** cycle 0 has only lane 2 valid (store, size 3, data 0xDEADBEEF) → one request with `req_lane`=2, `req_is_store`=1, `req_size`=3, `req_data`=0xDEADBEEF.
- **Backpressure:** hold `req_ready`=0 for 10 clocks while lanes 1 and 3 are pending → `req_valid`=1 with `req_lane`=1 and a stable payload throughout, and no `trace_read_ready` pulse.
- **Round-robin (`MEMTRACE_SEQ_RR_EN`):** lanes {0,1} valid, then lanes {0,1} valid again → order 0,1,0,1.
  - With lanes {1,2} then {0,2}: `rr_ptr`=3 after the first cycle, so the next order is 0,2.
  - Undefined macro: lowest index first.
- **Finish:** `trace_read_finished`=1 with lane 0 valid → lane 0 issued, then `done`=1 and no further fetch.
  - Finished with no lanes valid → DONE directly from LATCH.
- **Reset mid-ISSUE:** 2 lanes pending → `req_valid`=0 and `done`=0 during reset; the first FETCH after reset carries `trace_read_cycle`=0.

Source files
------------

// File: rtl/memtrace_seq_pkg.sv
// memtrace_seq_pkg: shared types and widths for the memory-trace replay sequencer
package memtrace_seq_pkg;
  localparam int MEMTRACE_DATA_WIDTH = 64;
  localparam int MEMTRACE_LOGSIZE_WIDTH = 8;
  localparam int MAX_NUM_LANES = 32;
  typedef enum logic [2:0] {START, FETCH, LATCH, ISSUE, DONE} seq_state_e;
endpackage

// File: rtl/memtrace_lane_picker.sv
// memtrace_lane_picker: picks one pending lane per handshake.
// Ports: pending (lane mask), ptr (round-robin start lane), grant (one-hot),
// index (encoded grant), any (some lane pending).
// Build option MEMTRACE_SEQ_RR_EN selects round-robin from ptr; otherwise the
// lowest pending lane wins and ptr is ignored.
module memtrace_lane_picker #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0] pending,
  input  logic [LANE_W-1:0]    ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [LANE_W-1:0]    index,
  output logic                 any
);
  logic [NUM_LANES-1:0] sel;
`ifdef MEMTRACE_SEQ_RR_EN
  logic [NUM_LANES-1:0] above;
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) above[i] = pending[i] && (LANE_W'(i) >= ptr);
  end
  // Lanes at or above the pointer take precedence; otherwise wrap to lane 0.
  assign sel = |above ? above : pending;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign sel = pending;
`endif
  // Isolate the lowest set bit.
  assign grant = sel & (-sel);
  assign any = |pending;
  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_LANES; i++) index = grant[i] ? LANE_W'(i) : index;
  end
endmodule

// File: rtl/memtrace_replay_sequencer.sv
// memtrace_replay_sequencer: steps a trace source cycle by cycle and serializes its lanes onto one request port.
// Ports: clock/reset (sync, active-high); trace_read_* fetch handshake and per-lane
// snapshot inputs; req_* single request channel with req_lane index; done (sticky).
// Build option MEMTRACE_SEQ_RR_EN enables round-robin lane grant (default: lowest lane first).
module memtrace_replay_sequencer
  import memtrace_seq_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W = MEMTRACE_DATA_WIDTH,
  parameter int SIZE_W = MEMTRACE_LOGSIZE_WIDTH,
  parameter int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        trace_read_ready,
  output logic [63:0]                 trace_read_cycle,
  input  logic [NUM_LANES-1:0]        trace_read_valid,
  input  logic [ADDR_W*NUM_LANES-1:0] trace_read_address,
  input  logic [NUM_LANES-1:0]        trace_read_is_store,
  input  logic [SIZE_W*NUM_LANES-1:0] trace_read_size,
  input  logic [ADDR_W*NUM_LANES-1:0] trace_read_data,
  input  logic                        trace_read_finished,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [ADDR_W-1:0]           req_address,
  output logic                        req_is_store,
  output logic [SIZE_W-1:0]           req_size,
  output logic [ADDR_W-1:0]           req_data,
  output logic [LANE_W-1:0]           req_lane,
  output logic                        done
);
  seq_state_e state;
  logic [63:0] counter;
  logic [NUM_LANES-1:0] pending, grant, rest;
  logic fin, any, fire;
  logic [ADDR_W*NUM_LANES-1:0] snap_addr, snap_data;
  logic [SIZE_W*NUM_LANES-1:0] snap_size;
  logic [NUM_LANES-1:0] snap_store;
`ifdef MEMTRACE_SEQ_RR_EN
  logic [LANE_W-1:0] rr_ptr;
`endif
  memtrace_lane_picker #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) u_picker (
    .pending(pending),
`ifdef MEMTRACE_SEQ_RR_EN
    .ptr(rr_ptr),
`else
    .ptr('0),
`endif
    .grant(grant),
    .index(req_lane),
    .any(any)
  );
  assign trace_read_ready = state == FETCH;
  assign trace_read_cycle = counter;
  assign done = state == DONE;
  assign req_valid = state == ISSUE && any;
  assign fire = req_valid && req_ready;
  assign rest = pending & ~grant;
  assign req_address = snap_addr[req_lane*ADDR_W +: ADDR_W];
  assign req_data = snap_data[req_lane*ADDR_W +: ADDR_W];
  assign req_size = snap_size[req_lane*SIZE_W +: SIZE_W];
  assign req_is_store = snap_store[req_lane];
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= START;
      counter <= '0;
      pending <= '0;
      fin <= 1'b0;
`ifdef MEMTRACE_SEQ_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        START: state <= FETCH;
        FETCH: begin
          counter <= counter + 64'd1;
          state <= LATCH;
        end
        LATCH: begin
          pending <= trace_read_valid;
          fin <= trace_read_finished;
          state <= |trace_read_valid ? ISSUE : trace_read_finished ? DONE : FETCH;
        end
        ISSUE: if (fire) begin
          pending <= rest;
`ifdef MEMTRACE_SEQ_RR_EN
          rr_ptr <= req_lane == LANE_W'(NUM_LANES - 1) ? '0 : req_lane + LANE_W'(1);
`endif
          // Leave on the same edge the last lane is accepted, so no idle bubble.
          if (rest == '0) state <= fin ? DONE : FETCH;
        end
        DONE: state <= DONE;
        default: state <= START;
      endcase
    end
  end
  // Snapshot needs no reset: pending gates every use of it.
  always_ff @(posedge clock) begin
    if (state == LATCH) begin
      snap_addr <= trace_read_address;
      snap_data <= trace_read_data;
      snap_size <= trace_read_size;
      snap_store <= trace_read_is_store;
    end
  end
endmodule

// File: tb/tb_memtrace_replay_sequencer.sv
// tb_memtrace_replay_sequencer: directed self-checking bench with a table-driven trace source.
module tb_memtrace_replay_sequencer;
  localparam int NL = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic trace_read_ready, trace_read_finished, req_valid, req_ready, req_is_store, done;
  logic [63:0] trace_read_cycle, req_address, req_data;
  logic [NL-1:0] trace_read_valid, trace_read_is_store;
  logic [64*NL-1:0] trace_read_address, trace_read_data;
  logic [8*NL-1:0] trace_read_size;
  logic [7:0] req_size;
  logic [1:0] req_lane;
  int cyc = 0;
  int rst_cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [NL-1:0] t_valid [8];
  logic [NL-1:0] t_store [8];
  logic [63:0] t_addr [8][NL];
  logic [63:0] t_data [8][NL];
  logic [7:0] t_size [8][NL];
  logic t_fin [8];
  int fetch_cyc[$];
  logic [63:0] fetch_num[$];
  int rq_lane[$];
  int rq_cyc[$];
  logic [63:0] rq_addr[$];
  logic [63:0] rq_data[$];
  logic [7:0] rq_size[$];
  logic rq_store[$];
  memtrace_replay_sequencer dut (
    .clock(clock), .reset(reset),
    .trace_read_ready(trace_read_ready), .trace_read_cycle(trace_read_cycle),
    .trace_read_valid(trace_read_valid), .trace_read_address(trace_read_address),
    .trace_read_is_store(trace_read_is_store), .trace_read_size(trace_read_size),
    .trace_read_data(trace_read_data), .trace_read_finished(trace_read_finished),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_is_store(req_is_store), .req_size(req_size), .req_data(req_data),
    .req_lane(req_lane), .done(done)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin : src
    int c;
    if (trace_read_ready) begin
      if (trace_read_cycle < 64'd8) begin
        c = int'(trace_read_cycle[2:0]);
        trace_read_valid = t_valid[c];
        trace_read_is_store = t_store[c];
        trace_read_finished = t_fin[c];
        for (int l = 0; l < NL; l++) begin
          trace_read_address[64*l +: 64] = t_addr[c][l];
          trace_read_data[64*l +: 64] = t_data[c][l];
          trace_read_size[8*l +: 8] = t_size[c][l];
        end
      end else begin
        trace_read_valid = '0;
        trace_read_finished = 1'b1;
      end
    end
  end
  always @(negedge clock) begin
    if (trace_read_ready) begin
      fetch_cyc.push_back(cyc);
      fetch_num.push_back(trace_read_cycle);
    end
    if (req_valid && req_ready) begin
      rq_lane.push_back(int'(req_lane));
      rq_cyc.push_back(cyc);
      rq_addr.push_back(req_address);
      rq_data.push_back(req_data);
      rq_size.push_back(req_size);
      rq_store.push_back(req_is_store);
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_tab();
    for (int c = 0; c < 8; c++) begin
      t_valid[c] = '0;
      t_store[c] = '0;
      t_fin[c] = 1'b1;
      for (int l = 0; l < NL; l++) begin
        t_addr[c][l] = '0;
        t_data[c][l] = '0;
        t_size[c][l] = '0;
      end
    end
  endtask
  task automatic set_lane(input int c, input int l, input logic [63:0] a, input logic s,
                          input logic [7:0] z, input logic [63:0] d);
    t_valid[c][l] = 1'b1;
    t_store[c][l] = s;
    t_addr[c][l] = a;
    t_size[c][l] = z;
    t_data[c][l] = d;
  endtask
  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_trace_ready", trace_read_ready, 0);
    check("rst_trace_cycle", trace_read_cycle, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_lane", req_lane, 0);
    check("rst_done", done, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    rst_cyc = cyc;
    fetch_cyc.delete();
    fetch_num.delete();
    rq_lane.delete();
    rq_cyc.delete();
    rq_addr.delete();
    rq_data.delete();
    rq_size.delete();
    rq_store.delete();
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && !done; i++) @(negedge clock);
    check({tag, "_done"}, done, 1);
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !req_valid; i++) @(negedge clock);
    check({tag, "_valid"}, req_valid, 1);
  endtask
  task automatic check_lanes(input string tag, input int n, input logic [31:0] seq);
    check({tag, "_count"}, rq_lane.size(), n);
    for (int i = 0; i < n && i < rq_lane.size(); i++)
      check({tag, "_lane"}, rq_lane[i], seq[4*(n-1-i) +: 4]);
  endtask
  initial begin
    req_ready = 1'b1;
    trace_read_valid = '0;
    trace_read_is_store = '0;
    trace_read_address = '0;
    trace_read_data = '0;
    trace_read_size = '0;
    trace_read_finished = 1'b0;
    clear_tab();
    for (int l = 0; l < NL; l++) set_lane(0, l, 64'h1000 + 64'(8 * l), 1'b0, 8'd3, 64'hA0 + 64'(l));
    t_fin[0] = 1'b0;
    do_reset();
    wait_done("full");
    check_lanes("full", 4, 32'h0123);
    for (int i = 0; i < 4 && i < rq_addr.size(); i++) begin
      check("full_addr", rq_addr[i], 64'h1000 + 64'(8 * i));
      check("full_data", rq_data[i], 64'hA0 + 64'(i));
    end
    check("full_fetches", fetch_cyc.size(), 2);
    check("full_first_fetch_cyc", fetch_cyc[0], rst_cyc + 1);
    check("full_first_fetch_num", fetch_num[0], 0);
    check("full_second_fetch_num", fetch_num[1], 1);
    check("full_fetch_gap", fetch_cyc[1] - fetch_cyc[0], 6);
    check("full_first_req_cyc", rq_cyc[0] - fetch_cyc[0], 2);
    check("full_consecutive", rq_cyc[3] - rq_cyc[0], 3);
    clear_tab();
    set_lane(0, 2, 64'h2000, 1'b1, 8'd3, 64'hDEADBEEF);
    t_fin[0] = 1'b0;
    do_reset();
    wait_done("sparse");
    check_lanes("sparse", 1, 32'h2);
    check("sparse_addr", rq_addr[0], 64'h2000);
    check("sparse_store", rq_store[0], 1);
    check("sparse_size", rq_size[0], 3);
    check("sparse_data", rq_data[0], 64'hDEADBEEF);
    check("sparse_fetches", fetch_cyc.size(), 2);
    clear_tab();
    set_lane(0, 1, 64'h3008, 1'b0, 8'd2, 64'h11);
    set_lane(0, 3, 64'h3018, 1'b1, 8'd1, 64'h33);
    t_fin[0] = 1'b0;
    req_ready = 1'b0;
    do_reset();
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", req_valid, 1);
      check("bp_lane", req_lane, 1);
      check("bp_addr", req_address, 64'h3008);
      check("bp_size", req_size, 2);
      check("bp_no_fetch", trace_read_ready, 0);
      @(negedge clock);
    end
    check("bp_fetch_count", fetch_cyc.size(), 1);
    @(posedge clock);
    #1 req_ready = 1'b1;
    wait_done("bp");
    check_lanes("bp", 2, 32'h13);
    check("bp_lane3_data", rq_data[1], 64'h33);
    clear_tab();
    set_lane(0, 1, 64'h10, 1'b0, 8'd0, 64'h0);
    set_lane(0, 2, 64'h20, 1'b0, 8'd0, 64'h0);
    set_lane(1, 0, 64'h30, 1'b0, 8'd0, 64'h0);
    set_lane(1, 2, 64'h40, 1'b0, 8'd0, 64'h0);
    set_lane(2, 1, 64'h50, 1'b0, 8'd0, 64'h0);
    set_lane(3, 0, 64'h60, 1'b0, 8'd0, 64'h0);
    set_lane(3, 2, 64'h70, 1'b0, 8'd0, 64'h0);
    t_fin[0] = 1'b0;
    t_fin[1] = 1'b0;
    t_fin[2] = 1'b0;
    do_reset();
    wait_done("order");
`ifdef MEMTRACE_SEQ_RR_EN
    check_lanes("order", 7, 32'h1202120);
`else
    check_lanes("order", 7, 32'h1202102);
`endif
    check("order_fetches", fetch_cyc.size(), 4);
    clear_tab();
    set_lane(0, 0, 64'h4000, 1'b0, 8'd0, 64'h5);
    do_reset();
    wait_done("fin");
    check_lanes("fin", 1, 32'h0);
    repeat (5) @(negedge clock);
    check("fin_fetch_count", fetch_cyc.size(), 1);
    check("fin_done_sticky", done, 1);
    check("fin_req_valid", req_valid, 0);
    check("fin_trace_ready", trace_read_ready, 0);
    clear_tab();
    set_lane(0, 0, 64'h5000, 1'b0, 8'd0, 64'h0);
    set_lane(0, 1, 64'h5008, 1'b0, 8'd0, 64'h0);
    t_fin[0] = 1'b0;
    req_ready = 1'b0;
    do_reset();
    wait_valid("midrst");
    req_ready = 1'b1;
    do_reset();
    wait_done("midrst");
    check("midrst_first_fetch_num", fetch_num[0], 0);
    check("midrst_first_fetch_cyc", fetch_cyc[0], rst_cyc + 1);
    check_lanes("midrst", 2, 32'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
